// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: pipeline W-stage write, long-latency result
// handshake, decode hazard check and register-file write port.
interface wb_arbiter_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          pipe_we;
    logic [AW-1:0] pipe_a3;
    logic [DW-1:0] pipe_wd;
    logic          lr_valid;
    logic [AW-1:0] lr_a3;
    logic [DW-1:0] lr_wd;
    logic          lr_ready;
    logic [AW-1:0] chk_a1;
    logic [AW-1:0] chk_a2;
    logic          hazard;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;

    // Arbiter side
    modport slave (
        input  pipe_we, pipe_a3, pipe_wd,
        input  lr_valid, lr_a3, lr_wd,
        input  chk_a1, chk_a2,
        output lr_ready, hazard, pipe_stall,
        output rf_we, rf_a3, rf_wd
    );

    // Pipeline / register-file side
    modport master (
        output pipe_we, pipe_a3, pipe_wd,
        output lr_valid, lr_a3, lr_wd,
        output chk_a1, chk_a2,
        input  lr_ready, hazard, pipe_stall,
        input  rf_we, rf_a3, rf_wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the W stage and a 2-entry buffer of
// long-latency results. Optional anti-starvation logic: define WB_ARB_FAIR_EN.
module wb_arbiter (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
    } entry_t;

    entry_t     fifo_q [DEPTH];
    logic [1:0] count_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;

    logic       pipe_req_c;
    logic       lr_ready_c;
    logic       push_c;
    logic       pipe_win_c;
    logic       pop_c;
    logic       stall_c;
    logic       hit_a1_c;
    logic       hit_a2_c;
    entry_t     head_c;
    entry_t     tail_c;

    // Handshake and grant decisions; $0 writes never claim the port or buffer
    always_comb begin
        head_c     = fifo_q[rd_ptr_q];
        tail_c     = fifo_q[~rd_ptr_q];
        pipe_req_c = bus.pipe_we && (bus.pipe_a3 != '0);
        lr_ready_c = (count_q < 2'd2) && !reset;
        push_c     = bus.lr_valid && lr_ready_c && (bus.lr_a3 != '0);
        pipe_win_c = !reset && !stall_c && pipe_req_c;
        pop_c      = !reset && !pipe_win_c && (count_q != 2'd0);
    end

    // Register-file port, zeroed whenever no write is granted
    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_a3 = '0;
        bus.rf_wd = '0;
        if (pipe_win_c) begin
            bus.rf_we = 1'b1;
            bus.rf_a3 = bus.pipe_a3;
            bus.rf_wd = bus.pipe_wd;
        end else if (pop_c) begin
            bus.rf_we = 1'b1;
            bus.rf_a3 = head_c.a3;
            bus.rf_wd = head_c.wd;
        end
    end

    // Hazard covers every valid entry, including one that pops this cycle
    always_comb begin
        hit_a1_c = ((count_q != 2'd0) && (head_c.a3 == bus.chk_a1)) ||
                   ((count_q == 2'd2) && (tail_c.a3 == bus.chk_a1));
        hit_a2_c = ((count_q != 2'd0) && (head_c.a3 == bus.chk_a2)) ||
                   ((count_q == 2'd2) && (tail_c.a3 == bus.chk_a2));
    end

    assign bus.hazard     = !reset && (((bus.chk_a1 != '0) && hit_a1_c) ||
                                       ((bus.chk_a2 != '0) && hit_a2_c));
    assign bus.lr_ready   = lr_ready_c;
    assign bus.pipe_stall = stall_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{a3: bus.lr_a3, wd: bus.lr_wd};
        end
    end

`ifdef WB_ARB_FAIR_EN
    logic [1:0] age_q;
    logic       force_q;
    logic       lose_c;

    assign lose_c  = (count_q != 2'd0) && pipe_win_c;
    assign stall_c = force_q && !reset;

    // After four consecutive losses the next cycle is reserved for the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q   <= 2'd0;
            force_q <= 1'b0;
        end else if (pop_c || (count_q == 2'd0)) begin
            age_q   <= 2'd0;
            force_q <= 1'b0;
        end else if (lose_c) begin
            if (age_q == 2'd3) begin
                force_q <= 1'b1;
            end else begin
                age_q <= age_q + 2'd1;
            end
        end
    end
`else
    assign stall_c = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-cycle vector table plus a
// starvation sequence whose expectations follow WB_ARB_FAIR_EN.
module tb_wb_arbiter;
    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  pa3;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  la3;
        logic [31:0] lwd;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd;
        logic        erdy;
        logic        ehz;
        logic        est;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   row   = 0;
    vec_t vecs [$];
    vec_t exp_q [$];

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
        input logic lv, input logic [4:0] la3, input logic [31:0] lwd,
        input logic [4:0] c1, input logic [4:0] c2,
        input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
        input logic erdy, input logic ehz, input logic est);
        vec_t v;
        v.rst = rst; v.pwe = pwe; v.pa3 = pa3; v.pwd = pwd;
        v.lv = lv; v.la3 = la3; v.lwd = lwd; v.c1 = c1; v.c2 = c2;
        v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd; v.erdy = erdy; v.ehz = ehz; v.est = est;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, want);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check before the edge
    task automatic apply(input vec_t v);
        vec_t e;
        reset        = v.rst;
        bus.pipe_we  = v.pwe;
        bus.pipe_a3  = v.pa3;
        bus.pipe_wd  = v.pwd;
        bus.lr_valid = v.lv;
        bus.lr_a3    = v.la3;
        bus.lr_wd    = v.lwd;
        bus.chk_a1   = v.c1;
        bus.chk_a2   = v.c2;
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL row %0d scoreboard: got empty expected entry", row);
        end else begin
            e = exp_q.pop_front();
            cmp("rf_we",      32'(bus.rf_we),      32'(e.ewe));
            cmp("rf_a3",      32'(bus.rf_a3),      32'(e.ea3));
            cmp("rf_wd",      bus.rf_wd,           e.ewd);
            cmp("lr_ready",   32'(bus.lr_ready),   32'(e.erdy));
            cmp("hazard",     32'(bus.hazard),     32'(e.ehz));
            cmp("pipe_stall", 32'(bus.pipe_stall), 32'(e.est));
        end
        row++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic fair;
`ifdef WB_ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        //          rst pwe pa3 pwd       lv la3 lwd       c1  c2   we a3  wd        rdy hz st
        vecs.push_back(mk(1, 1, 5, 32'h1234, 1, 7, 32'h7,    7,  0,   0, 0,  32'h0,    0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0, 0,  32'h0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 32'h1234, 0, 0, 32'h0,    0,  0,   1, 5,  32'h1234, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 8, 32'hAA,   0,  0,   0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8,  0,   1, 8,  32'hAA,   1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8,  0,   0, 0,  32'h0,    1, 0, 0));
        // backpressure: pipe keeps the port while two results queue up
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 10, 32'h100, 0,  0,   1, 1,  32'h11,   1, 0, 0));
        vecs.push_back(mk(0, 1, 2, 32'h22,   1, 11, 32'h101, 0,  0,   1, 2,  32'h22,   1, 0, 0));
        vecs.push_back(mk(0, 1, 3, 32'h33,   1, 12, 32'h102, 0,  0,   1, 3,  32'h33,   0, 0, 0));
        vecs.push_back(mk(0, 1, 4, 32'h44,   1, 12, 32'h102, 11, 0,   1, 4,  32'h44,   0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   1, 10, 32'h100,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   1, 11, 32'h101,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    12, 0,   0, 0,  32'h0,    1, 0, 0));
        // zero register on both sources
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 3, 32'h333,  0,  0,   0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0, 32'h0,    0,  0,   1, 3,  32'h333,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h5,    0,  0,   0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0, 0,  32'h0,    1, 0, 0));
        // simultaneous push and pop
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 20, 32'hA20, 0,  0,   0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 21, 32'hA21, 0,  0,   1, 20, 32'hA20,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  21,  1, 21, 32'hA21,  1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0, 0,  32'h0,    1, 0, 0));
        // hazard against a buffered destination
        vecs.push_back(mk(0, 1, 6, 32'h66,   1, 9, 32'h99,   0,  0,   1, 6,  32'h66,   1, 0, 0));
        vecs.push_back(mk(0, 1, 7, 32'h77,   0, 0, 32'h0,    9,  0,   1, 7,  32'h77,   1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   1, 9,  32'h99,   1, 0, 0));
        // reset mid-operation drops both buffered results
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 13, 32'hD,   0,  0,   0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 1, 15, 32'hF,   1, 14, 32'hE,   0,  0,   1, 15, 32'hF,    1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    13, 0,   0, 0,  32'h0,    0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    13, 14,  0, 0,  32'h0,    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0, 0,  32'h0,    1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // starvation: one buffered result, pipe writing every cycle
        apply(mk(0, 0, 0, 32'h0, 1, 16, 32'h160, 0, 0, 0, 0, 32'h0, 1, 0, 0));
        k = 1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (fair && cyc == 5) begin
                apply(mk(0, 1, 5'(16 + k), 32'(k), 0, 0, 32'h0, 0, 0,
                         1, 16, 32'h160, 1, 0, 1));
            end else begin
                apply(mk(0, 1, 5'(16 + k), 32'(k), 0, 0, 32'h0, 0, 0,
                         1, 5'(16 + k), 32'(k), 1, 0, 0));
                k++;
            end
        end
        if (fair) begin
            apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 16, 0, 0, 0, 32'h0, 1, 0, 0));
        end else begin
            apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 16, 0, 1, 16, 32'h160, 1, 1, 0));
        end
        apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 16, 0, 0, 0, 32'h0, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset (1 = reset, sampled only on the clk edge).
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 pipe_we  input  1  W-stage register write request.
REQ-005 pipe_a3  input  5  W-stage destination register.
REQ-006 pipe_wd  input  32  W-stage write data (writeback mux result).
REQ-007 lr_valid  input  1  long-latency unit (mult/div) result valid.
REQ-008 lr_a3  input  5  long-latency destination register.
REQ-009 lr_wd  input  32  long-latency result data.
REQ-010 lr_ready  output  1  buffer can accept an lr result this cycle.
REQ-011 chk_a1, chk_a2  input  5 each  D-stage source registers for hazard check.
REQ-012 hazard  output  1  a source register matches a buffered, unwritten destination.
REQ-013 pipe_stall  output  1  the pipeline SHALL hold its W stage this cycle.
REQ-014 rf_we, rf_a3, rf_wd  output  1/5/32  register-file write port.

Function
REQ-015 Pipe request = pipe_we && pipe_a3 != 0; a write to $0 is not a request and does not occupy the port.
REQ-016 Buffer: 2-entry FIFO of {a3, wd}; count 0..2; lr_ready = (count < 2) && !reset, combinational.
REQ-017 Push on lr_valid && lr_ready && lr_a3 != 0; lr_a3 == 0 is accepted (handshake completes) but discarded.
REQ-018 Grant, combinational: if pipe_stall = 0 and pipe request, the pipe wins (rf = pipe_a3/pipe_wd); else if count > 0, the buffer head wins and pops at the clock edge; else rf_we = 0.
REQ-019 Latency: pipe write passes to rf in the same cycle; a buffered result is written no earlier than the cycle after it is accepted.
REQ-020 Push and pop in the same cycle SHALL both take effect; count is unchanged, and FIFO order is preserved.
REQ-021 When rf_we = 0, rf_a3 SHALL be 0 and rf_wd SHALL be 0.
REQ-022 hazard = 1 when chk_a1 or chk_a2 is nonzero and equals the a3 of any valid buffer entry, including an entry popping this cycle.
REQ-023 No WAW ordering between the pipe and the buffer is enforced; the decode stage uses hazard to avoid it.
REQ-024 Without the fairness feature, pipe_stall SHALL be constant 0.

Reset
REQ-025 While reset = 1: rf_we = 0, rf_a3 = 0, rf_wd = 0, lr_ready = 0, hazard = 0, pipe_stall = 0.
REQ-026 On the first clock edge with reset = 1, count, the FIFO pointers, age and force SHALL be cleared; buffered entries are dropped.
REQ-027 Reset asserted in the middle of an operation SHALL discard pending results without writing them.

Configuration
REQ-028 Macro WB_ARB_FAIR_EN enables anti-starvation logic; when it is undefined, the age and force registers SHALL be absent.
REQ-029 With WB_ARB_FAIR_EN, a 2-bit age counter SHALL:
 - increment on each cycle where count > 0 and the buffer loses to the pipe;
 - clear on any pop or when count = 0.
REQ-030 With WB_ARB_FAIR_EN, when age = 3 and the buffer loses again, force SHALL be set for the next cycle.
REQ-031 With WB_ARB_FAIR_EN, in a force cycle: pipe_stall = 1 and the buffer head wins; force and age then clear.
REQ-032 The pipeline SHALL re-present its held write in the following cycle.

Verification
REQ-033 Pipe only: pipe_we=1, a3=5, wd=0x1234 -> same cycle rf_we=1, rf_a3=5, rf_wd=0x1234.
REQ-034 Buffer drain: lr a3=8, wd=0xAA with the pipe idle -> next cycle rf_we=1, a3=8, wd=0xAA, then count=0.
REQ-035 Full/backpressure:
 - stimulus: two lr pushes while the pipe writes continuously;
 - required: lr_ready=0, and a third lr_valid is not accepted.
 - release: pipe idle -> entries written in order, one per cycle.
REQ-036 Zero register:
 - stimulus: pipe a3=0 with the buffer holding a3=3;
 - required: the buffer writes $3 that cycle.
 - stimulus: lr a3=0;
 - required: accepted, count unchanged.
REQ-037 Hazard: buffer holds a3=9; chk_a1=9 -> hazard=1; chk_a1=0, chk_a2=0 -> hazard=0.
REQ-038 WB_ARB_FAIR_EN:
 - stimulus: buffer non-empty, pipe writing every cycle;
 - required: on the 5th cycle pipe_stall=1 and the buffer head is written.
 - without the macro: the buffer waits indefinitely and pipe_stall stays 0.
